// File: rtl/vx_tcu_fp_sched_pkg.sv
// VX_tcu_pkg: shared definitions for the TCU floating-point scheduling logic.
//   - latency-class encodings (TCU_LAT_SHORT / TCU_LAT_LONG)
//   - operand/result format codes and the format -> latency-class decode
//   - tcu_sched_meta_t: per-op metadata carried alongside the datapath
package VX_tcu_pkg;

  localparam logic TCU_LAT_SHORT = 1'b0;
  localparam logic TCU_LAT_LONG  = 1'b1;

  localparam logic [2:0] TCU_FMT_FP32 = 3'd0;
  localparam logic [2:0] TCU_FMT_FP16 = 3'd1;
  localparam logic [2:0] TCU_FMT_BF16 = 3'd2;
  localparam logic [2:0] TCU_FMT_TF32 = 3'd3;

  localparam int TCU_UUID_W = 7;
  localparam int TCU_WID_W  = 4;
  localparam int TCU_PC_W   = 32;
  localparam int TCU_RD_W   = 5;

  typedef struct packed {
    logic [TCU_UUID_W-1:0] uuid;
    logic [TCU_WID_W-1:0]  wid;
    logic [TCU_PC_W-1:0]   pc;
    logic [TCU_RD_W-1:0]   rd;
  } tcu_sched_meta_t;

  // Half-width sources accumulating into fp32 take the short pipe; full-width
  // sources, or any non-fp32 destination, take the long pipe.
  function automatic logic tcu_lat_sel(input logic [2:0] fmt_s,
                                       input logic [2:0] fmt_d);
    logic wide_src;
    wide_src = (fmt_s == TCU_FMT_FP32) || (fmt_s == TCU_FMT_TF32);
    return (wide_src || (fmt_d != TCU_FMT_FP32)) ? TCU_LAT_LONG : TCU_LAT_SHORT;
  endfunction

endpackage

// File: rtl/vx_tcu_fp_sched_fifo.sv
// VX_fifo_queue: synchronous FIFO built from a register array.
//   clk, reset   : clock, synchronous active-high reset (empties the queue)
//   push/data_in : write request and data
//   pop/data_out : read request and head data (valid while !empty)
//   empty, full  : occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module VX_fifo_queue #(
  parameter int DATAW = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CNTW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNTW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vx_tcu_fp_sched.sv
// vx_tcu_fp_sched: issue/retire controller for the FEDP datapath with two
// latency classes. Ops launch on dp_issue, the datapath returns dp_result
// exactly LAT cycles later, and results retire in issue order through an
// output FIFO. Admission is gated by credits (one per output FIFO slot) and
// by an ordering check that stops a short op overtaking a long one.
//   clk, reset                : clock, synchronous active-high reset
//   in_valid/in_ready         : request handshake
//   in_lat_sel                : 0 = short class, 1 = long class
//   in_meta                   : per-op metadata
//   dp_issue, dp_lat_sel      : datapath launch pulse and its class
//   dp_result                 : datapath result, captured on completion
//   out_valid/out_ready       : result handshake
//   out_meta, out_data        : head-of-FIFO result
//   busy                      : some op is outstanding
module vx_tcu_fp_sched
  import VX_tcu_pkg::*;
#(
  parameter int DATAW     = 256,
  parameter int MDATA_W   = 48,
  parameter int LAT_SHORT = 4,
  parameter int LAT_LONG  = 8,
  parameter int OUT_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_lat_sel,
  input  logic [MDATA_W-1:0] in_meta,
  output logic               dp_issue,
  output logic               dp_lat_sel,
  input  logic [DATAW-1:0]   dp_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MDATA_W-1:0] out_meta,
  output logic [DATAW-1:0]   out_data,
  output logic               busy
);

  localparam int CREDW = $clog2(OUT_DEPTH + 1);
  localparam logic [CREDW-1:0] CRED_MAX = CREDW'(OUT_DEPTH);

  // Pipe slots a short op could collide with or overtake: LAT_SHORT and above.
  localparam logic [LAT_LONG-1:0] ORDER_MASK = {LAT_LONG{1'b1}} << LAT_SHORT;
  localparam logic [LAT_LONG-1:0] SHORT_BIT  = LAT_LONG'(1) << (LAT_SHORT - 1);
  localparam logic [LAT_LONG-1:0] LONG_BIT   = LAT_LONG'(1) << (LAT_LONG - 1);

  logic [LAT_LONG-1:0] pipe;
  logic [CREDW-1:0]    credits;
  logic                lat_long;
  logic                order_ok;
  logic                in_fire;
  logic                out_fire;
  logic                complete;

  logic [MDATA_W-1:0]       meta_head;
  logic                     meta_empty;
  logic                     meta_full;
  logic [MDATA_W+DATAW-1:0] out_q_data;
  logic                     out_empty;
  logic                     out_full;

  assign lat_long = (in_lat_sel == TCU_LAT_LONG);
  assign order_ok = lat_long || ((pipe & ORDER_MASK) == '0);
  assign in_ready = (credits != '0) && order_ok;
  assign in_fire  = in_valid && in_ready && !reset;
  assign out_fire = out_valid && out_ready;
  assign complete = pipe[0];

  assign dp_issue   = in_fire;
  assign dp_lat_sel = in_lat_sel;
  assign busy       = (credits != CRED_MAX);
  assign out_valid  = !out_empty;
  assign {out_meta, out_data} = out_q_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe <= (pipe >> 1) | (in_fire ? (lat_long ? LONG_BIT : SHORT_BIT) : '0);
    end
  end

  // A credit covers an op from issue until it leaves the output FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits <= CRED_MAX;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  VX_fifo_queue #(
    .DATAW (MDATA_W),
    .DEPTH (OUT_DEPTH)
  ) meta_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (in_fire),
    .pop      (complete),
    .data_in  (in_meta),
    .data_out (meta_head),
    .empty    (meta_empty),
    .full     (meta_full)
  );

  VX_fifo_queue #(
    .DATAW (MDATA_W + DATAW),
    .DEPTH (OUT_DEPTH)
  ) out_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (complete),
    .pop      (out_fire),
    .data_in  ({meta_head, dp_result}),
    .data_out (out_q_data),
    .empty    (out_empty),
    .full     (out_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (credits <= CRED_MAX);
      assert (!(complete && meta_empty));
      assert (!(complete && out_full));
      assert (!(in_fire && meta_full));
    end
  end

endmodule

// File: tb/tb_vx_tcu_fp_sched.sv
module tb_vx_tcu_fp_sched;
  import VX_tcu_pkg::*;

  localparam int DW = 256;
  localparam int MW = 48;
  localparam int LS = 4;
  localparam int LL = 8;
  localparam int OD = 8;
  localparam int CW = 512;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_lat_sel;
  logic [MW-1:0] in_meta;
  logic          dp_issue;
  logic          dp_lat_sel;
  logic [DW-1:0] dp_result;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_meta;
  logic [DW-1:0] out_data;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [MW+DW-1:0] sb[$];
  logic [MW+DW-1:0] sb_exp;

  vx_tcu_fp_sched #(
    .DATAW(DW), .MDATA_W(MW), .LAT_SHORT(LS), .LAT_LONG(LL), .OUT_DEPTH(OD)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_lat_sel(in_lat_sel), .in_meta(in_meta),
    .dp_issue(dp_issue), .dp_lat_sel(dp_lat_sel), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_meta(out_meta), .out_data(out_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: the result returned in a cycle is a function of that cycle.
  function automatic logic [DW-1:0] fdata(input int c);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = 32'(c) * 32'h9E3779B9 + 32'(i);
    return r;
  endfunction

  assign dp_result = fdata(cyc);

  task automatic chk(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: expected entry built when an op is accepted, compared on retire.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", CW'(1), CW'(0));
        end else begin
          sb_exp = sb.pop_front();
          chk("out_meta", CW'(out_meta), CW'(sb_exp[MW+DW-1:DW]));
          chk("out_data", CW'(out_data), CW'(sb_exp[DW-1:0]));
        end
      end
      if (in_valid && in_ready)
        sb.push_back({in_meta, fdata(cyc + (in_lat_sel ? LL : LS))});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mk_meta(input int n, output logic [MW-1:0] m);
    tcu_sched_meta_t t;
    t.uuid = TCU_UUID_W'(n);
    t.wid  = TCU_WID_W'(n * 3);
    t.pc   = 32'h8000_0000 + 32'(n * 4);
    t.rd   = TCU_RD_W'(n + 1);
    m = t;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_lat_sel = 1'b0; in_meta = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    #1;
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (16) step();
    chk(tag, CW'(sb.size()), CW'(0));
    chk({tag, "_busy"}, CW'(busy), CW'(0));
  endtask

  task automatic single_long(input int id);
    logic [MW-1:0] m;
    mk_meta(id, m);
    in_valid = 1'b1; in_lat_sel = 1'b1; in_meta = m; out_ready = 1'b1;
    #1;
    chk("s1_issue", CW'(dp_issue), CW'(1));
    chk("s1_lat_sel", CW'(dp_lat_sel), CW'(1));
    step();
    in_valid = 1'b0;
    #1;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) begin step(); #1; end
      chk($sformatf("s1_valid_c%0d", k), CW'(out_valid), CW'(k == 9));
      chk($sformatf("s1_busy_c%0d", k), CW'(busy), CW'(k <= 9));
    end
  endtask

  logic [MW-1:0] m;
  logic [LL-1:0] mpipe;
  int mcred;
  int acc;
  logic exp_rdy, fire, pop;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_lat_sel = 1'b0; in_meta = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_out_valid", CW'(out_valid), CW'(0));
    chk("rst_in_ready", CW'(in_ready), CW'(1));
    chk("rst_busy", CW'(busy), CW'(0));
    chk("rst_dp_issue", CW'(dp_issue), CW'(0));

    // single long op
    single_long(1);
    drain("s1_drain");

    // long then short: short is held off until the long op is past its slot
    mk_meta(2, m);
    in_valid = 1'b1; in_lat_sel = 1'b1; in_meta = m;
    step();
    mk_meta(3, m);
    in_lat_sel = 1'b0; in_meta = m;
    #1;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin step(); #1; end
      chk($sformatf("ls_ready_c%0d", k), CW'(in_ready), CW'(k == 5));
    end
    step();
    in_valid = 1'b0;
    #1;
    for (int k = 6; k <= 11; k++) begin
      if (k > 6) begin step(); #1; end
      chk($sformatf("ls_valid_c%0d", k), CW'(out_valid), CW'(k == 9 || k == 10));
    end
    drain("ls_drain");

    // short then long back-to-back
    mk_meta(4, m);
    in_valid = 1'b1; in_lat_sel = 1'b0; in_meta = m;
    step();
    mk_meta(5, m);
    in_lat_sel = 1'b1; in_meta = m;
    #1;
    chk("sl_ready_c1", CW'(in_ready), CW'(1));
    step();
    in_valid = 1'b0;
    #1;
    for (int k = 2; k <= 11; k++) begin
      if (k > 2) begin step(); #1; end
      chk($sformatf("sl_valid_c%0d", k), CW'(out_valid), CW'(k == 5 || k == 10));
    end
    drain("sl_drain");

    // backpressure: exactly OD accepted, a pop frees a credit only next cycle
    out_ready = 1'b0; in_valid = 1'b1; in_lat_sel = 1'b0;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      mk_meta(10 + k, m);
      in_meta = m;
      #1;
      if (in_ready) acc++;
      step();
    end
    mk_meta(30, m);
    in_meta = m;
    #1;
    chk("bp_accepted", CW'(acc), CW'(OD));
    chk("bp_ready_full", CW'(in_ready), CW'(0));
    chk("bp_valid_held", CW'(out_valid), CW'(1));
    out_ready = 1'b1;
    #1;
    chk("bp_ready_pop_cycle", CW'(in_ready), CW'(0));
    step();
    out_ready = 1'b0;
    #1;
    chk("bp_ready_after_pop", CW'(in_ready), CW'(1));
    step();
    mk_meta(31, m);
    in_meta = m;
    #1;
    chk("bp_ready_refull", CW'(in_ready), CW'(0));
    drain("bp_drain");

    // simultaneous issue and retire with a single credit left
    out_ready = 1'b0; in_valid = 1'b1; in_lat_sel = 1'b0;
    for (int k = 0; k < OD - 1; k++) begin
      mk_meta(40 + k, m);
      in_meta = m;
      #1;
      chk($sformatf("c1_fill_%0d", k), CW'(in_ready), CW'(1));
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();
    mk_meta(50, m);
    in_valid = 1'b1; in_meta = m; out_ready = 1'b1;
    #1;
    chk("c1_ready_both", CW'(in_ready), CW'(1));
    chk("c1_valid_both", CW'(out_valid), CW'(1));
    step();
    mk_meta(51, m);
    in_meta = m; out_ready = 1'b0;
    #1;
    chk("c1_ready_kept", CW'(in_ready), CW'(1));
    step();
    in_valid = 1'b0;
    #1;
    chk("c1_ready_empty", CW'(in_ready), CW'(0));
    drain("c1_drain");

    // random traffic against a reference model of the admission rule
    do_reset();
    mpipe = '0;
    mcred = OD;
    for (int k = 0; k < 100; k++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_lat_sel = 1'($urandom_range(0, 1));
      in_meta    = MW'({$urandom, $urandom});
      out_ready  = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = (mcred != 0) && (in_lat_sel || (mpipe[LL-1:LS] == '0));
      chk($sformatf("rnd_ready_%0d", k), CW'(in_ready), CW'(exp_rdy));
      chk($sformatf("rnd_busy_%0d", k), CW'(busy), CW'(mcred != OD));
      fire = in_valid && exp_rdy;
      pop  = out_valid && out_ready;
      mpipe = (mpipe >> 1) | (fire ? (in_lat_sel ? (LL'(1) << (LL - 1)) : (LL'(1) << (LS - 1))) : '0);
      mcred = mcred - int'(fire) + int'(pop);
      @(posedge clk);
      #1;
    end
    drain("rnd_drain");

    // reset with ops in flight
    out_ready = 1'b0; in_valid = 1'b1; in_lat_sel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mk_meta(60 + k, m);
      in_meta = m;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("mr_issue_in_reset", CW'(dp_issue), CW'(0));
    sb.delete();
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mr_out_valid", CW'(out_valid), CW'(0));
    chk("mr_busy", CW'(busy), CW'(0));
    chk("mr_in_ready", CW'(in_ready), CW'(1));
    single_long(70);
    drain("mr_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
